// File: rtl/seq_booth_multiplier_if.sv
// Operand/product handshake bundle for the sequential Booth multiplier.
// The master offers operands and consumes the product; the slave is the multiplier.
interface seq_booth_multiplier_if #(
    parameter int unsigned WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   signed_mode;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;

    modport master (
        output in_valid, signed_mode, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, signed_mode, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth multiplier: one add/subtract-and-shift step per clock,
// signed or unsigned operands selected per operation, valid/ready on both sides.
module seq_booth_multiplier #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_booth_multiplier_if.slave  bus
);
    // One guard bit lets unsigned operands be treated as non-negative signed values.
    localparam int unsigned N  = WIDTH + 1;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [N-1:0]    q_q, q_d;
    logic            qm1_q, qm1_d;
    logic [N-1:0]    m_q, m_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   product_q, product_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic            accept_c;
    logic            last_step_c;
    logic [N-1:0]    ext_m_c, ext_q_c;
    logic [N-1:0]    sum_c;
    logic [N-1:0]    step_acc_c, step_q_c;
    logic            step_qm1_c;

    assign accept_c    = bus.in_valid && in_ready_q;
    assign last_step_c = (cnt_q == CW'(N - 1));
    assign ext_m_c     = bus.signed_mode ? {bus.multiplicand[WIDTH-1], bus.multiplicand}
                                         : {1'b0, bus.multiplicand};
    assign ext_q_c     = bus.signed_mode ? {bus.multiplier[WIDTH-1], bus.multiplier}
                                         : {1'b0, bus.multiplier};

    // Booth recode on {Q[0], q-1}, then arithmetic shift of {acc, Q, q-1}.
    always_comb begin
        sum_c = acc_q;
        case ({q_q[0], qm1_q})
            2'b10:   sum_c = acc_q - m_q;
            2'b01:   sum_c = acc_q + m_q;
            default: sum_c = acc_q;
        endcase
        step_acc_c = {sum_c[N-1], sum_c[N-1:1]};
        step_q_c   = {sum_c[0], q_q[N-1:1]};
        step_qm1_c = q_q[0];
    end

    // State register and all datapath/output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            q_q         <= '0;
            qm1_q       <= 1'b0;
            m_q         <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            q_q         <= q_d;
            qm1_q       <= qm1_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = CALC;
            CALC:    if (last_step_c) state_d = DONE;
            DONE:    if (out_valid_q && bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; handshake flags follow the next state.
    always_comb begin
        acc_d       = acc_q;
        q_d         = q_q;
        qm1_d       = qm1_q;
        m_d         = m_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    m_d   = ext_m_c;
                    q_d   = ext_q_c;
                    acc_d = '0;
                    qm1_d = 1'b0;
                    cnt_d = '0;
                end
            end
            CALC: begin
                acc_d = step_acc_c;
                q_d   = step_q_c;
                qm1_d = step_qm1_c;
                cnt_d = cnt_q + CW'(1);
                // Low 2*WIDTH bits of {acc, Q} after the final shift.
                if (last_step_c) product_d = {step_acc_c[WIDTH-2:0], step_q_c};
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign bus.busy      = busy_q;

endmodule
